sysbus_rr_arbiter: RTL and testbench

//  Round-robin owner of the single Sysbus master port, shared by the I-cache and the D-cache.

---
 rtl/sysbus_rr_arbiter.sv | 158 +++++++++++++++
 tb/tb_sysbus_rr_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sysbus_rr_arbiter.sv
// sysbus_rr_arbiter: round-robin owner of the single Sysbus master port,
// shared by the I-cache (read-only) and the D-cache (read/write).
// One requester owns the bus per transaction; its request beats are forwarded
// to the bus and response beats/acks are routed back to it only.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   ic_reqcyc/req/reqtag/reqack    I-cache request channel
//   ic_respcyc/respack             I-cache response handshake
//   dc_reqcyc/req/reqtag/reqack    D-cache request channel
//   dc_respcyc/respack             D-cache response handshake
//   bus_reqcyc/req/reqtag/reqack   Sysbus request channel
//   bus_respcyc/resp/resptag/respack  Sysbus response channel
//   grant_dc                       debug: D-cache currently owns the bus
module sysbus_rr_arbiter #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ic_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] ic_req,
  input  logic [BUS_TAG_WIDTH-1:0]  ic_reqtag,
  output logic                      ic_reqack,
  output logic                      ic_respcyc,
  input  logic                      ic_respack,
  input  logic                      dc_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] dc_req,
  input  logic [BUS_TAG_WIDTH-1:0]  dc_reqtag,
  output logic                      dc_reqack,
  output logic                      dc_respcyc,
  input  logic                      dc_respack,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      grant_dc
);

  localparam int unsigned CNT_W = $clog2(LINE_BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RESP} state_t;

  state_t             state, state_n;
  logic               owner, owner_n;   // 0 = I-cache, 1 = D-cache
  logic               last, last_n;     // last requester served
  logic [CNT_W-1:0]   cnt, cnt_n;

  logic                      own_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
  logic                      own_respack;

  // Response data/tag reach the caches directly on the bus wires.
  logic unused_resp;
  assign unused_resp = ^{bus_resp, bus_resptag};

  // Owner-selected request/response signals.
  assign own_reqcyc  = owner ? dc_reqcyc  : ic_reqcyc;
  assign own_req     = owner ? dc_req     : ic_req;
  assign own_reqtag  = owner ? dc_reqtag  : ic_reqtag;
  assign own_respack = owner ? dc_respack : ic_respack;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state and forwarding logic.
  always_comb begin
    state_n     = state;
    owner_n     = owner;
    last_n      = last;
    cnt_n       = cnt;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    ic_reqack   = 1'b0;
    dc_reqack   = 1'b0;
    ic_respcyc  = 1'b0;
    dc_respcyc  = 1'b0;
    bus_respack = 1'b0;
    grant_dc    = (state != IDLE) && owner;

    case (state)
      IDLE: begin
        if (ic_reqcyc || dc_reqcyc) begin
          state_n = ADDR;
          // On contention serve whoever was not served last.
          owner_n = (ic_reqcyc && dc_reqcyc) ? ~last : dc_reqcyc;
        end
      end
      ADDR, WDATA: begin
        bus_reqcyc = own_reqcyc;
        bus_req    = own_req;
        bus_reqtag = own_reqtag;
        ic_reqack  = !owner && bus_reqack;
        dc_reqack  = owner && bus_reqack;
        if (bus_reqack) begin
          if (state == ADDR) begin
            cnt_n   = '0;
            state_n = own_reqtag[BUS_TAG_WIDTH-1] ? RESP : WDATA;
          end else if (cnt == LAST_BEAT) begin
            cnt_n   = '0;
            last_n  = owner;
            state_n = IDLE;
          end else begin
            cnt_n = CNT_W'(cnt + 1'b1);
          end
        end
      end
      RESP: begin
        ic_respcyc  = !owner && bus_respcyc;
        dc_respcyc  = owner && bus_respcyc;
        bus_respack = own_respack;
        if (bus_respcyc && own_respack) begin
          if (cnt == LAST_BEAT) begin
            cnt_n   = '0;
            last_n  = owner;
            state_n = IDLE;
          end else begin
            cnt_n = CNT_W'(cnt + 1'b1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are silenced for the whole reset cycle, even mid-transaction.
    if (reset) begin
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      ic_reqack   = 1'b0;
      dc_reqack   = 1'b0;
      ic_respcyc  = 1'b0;
      dc_respcyc  = 1'b0;
      bus_respack = 1'b0;
      grant_dc    = 1'b0;
    end
  end

endmodule

// File: tb/tb_sysbus_rr_arbiter.sv
// Directed, table-driven bench for sysbus_rr_arbiter. Each record is one clock
// cycle: inputs applied after the falling edge, outputs compared 1 ns later.
module tb_sysbus_rr_arbiter;

  localparam int unsigned BDW = 64;
  localparam int unsigned BTW = 13;
  localparam logic [15:0] IC_A = 16'h1C00;
  localparam logic [15:0] DC_A = 16'hDC00;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           ic_reqcyc = 0, dc_reqcyc = 0;
  logic [BDW-1:0] ic_req = '0, dc_req = '0;
  logic [BTW-1:0] ic_reqtag = '0, dc_reqtag = '0;
  logic           ic_reqack, dc_reqack, ic_respcyc, dc_respcyc;
  logic           ic_respack = 0, dc_respack = 0;
  logic           bus_reqcyc, bus_respack, grant_dc;
  logic [BDW-1:0] bus_req;
  logic [BTW-1:0] bus_reqtag;
  logic           bus_reqack = 0, bus_respcyc = 0;
  logic [BDW-1:0] bus_resp = 64'h0123_4567_89AB_CDEF;
  logic [BTW-1:0] bus_resptag = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sysbus_rr_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_reqcyc(ic_reqcyc), .ic_req(ic_req), .ic_reqtag(ic_reqtag), .ic_reqack(ic_reqack),
    .ic_respcyc(ic_respcyc), .ic_respack(ic_respack),
    .dc_reqcyc(dc_reqcyc), .dc_req(dc_req), .dc_reqtag(dc_reqtag), .dc_reqack(dc_reqack),
    .dc_respcyc(dc_respcyc), .dc_respack(dc_respack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack), .grant_dc(grant_dc)
  );

  // in  = {reset, ic_reqcyc, ic_read, dc_reqcyc, dc_read, bus_reqack, bus_respcyc, ic_respack, dc_respack}
  // exp = {bus_reqcyc, ic_reqack, dc_reqack, ic_respcyc, dc_respcyc, bus_respack, grant_dc}
  typedef struct {
    string       name;
    logic [8:0]  in;
    logic [15:0] ic_d;
    logic [15:0] dc_d;
    logic [6:0]  exp;
    logic [15:0] exp_req;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] mkin(bit rst, bit icc, bit icrd, bit dcc, bit dcrd,
                                      bit back, bit brc, bit icra, bit dcra);
    return {rst, icc, icrd, dcc, dcrd, back, brc, icra, dcra};
  endfunction

  function automatic logic [6:0] mkex(bit breq, bit icack, bit dcack, bit icrc,
                                      bit dcrc, bit brack, bit gdc);
    return {breq, icack, dcack, icrc, dcrc, brack, gdc};
  endfunction

  task automatic add(input string n, input logic [8:0] in, input logic [15:0] icd,
                     input logic [15:0] dcd, input logic [6:0] ex, input logic [15:0] er);
    vec_t v;
    v.name = n; v.in = in; v.ic_d = icd; v.dc_d = dcd; v.exp = ex; v.exp_req = er;
    vecs.push_back(v);
  endtask

  // One full read transaction by `dco` (1 = D-cache); `other` keeps the
  // other cache requesting throughout.
  task automatic read_txn(input string n, input bit dco, input bit other);
    bit icc, dcc;
    icc = !dco || other;
    dcc = dco || other;
    add({n, "_idle"}, mkin(0, icc, 1, dcc, 1, 0, 0, 0, 0), IC_A, DC_A, 7'd0, 16'h0);
    add({n, "_addr"}, mkin(0, icc, 1, dcc, 1, 1, 0, 0, 0), IC_A, DC_A,
        mkex(1, !dco, dco, 0, 0, 0, dco), dco ? DC_A : IC_A);
    for (int k = 0; k < 8; k++)
      add({n, "_beat"}, mkin(0, icc, 1, dcc, 1, 0, 1, !dco, dco), IC_A, DC_A,
          mkex(0, 0, 0, !dco, dco, 1, dco), 16'h0);
  endtask

  task automatic apply(input vec_t v);
    reset       = v.in[8];
    ic_reqcyc   = v.in[7];
    ic_reqtag   = {v.in[6], 12'h111};
    dc_reqcyc   = v.in[5];
    dc_reqtag   = {v.in[4], 12'h222};
    bus_reqack  = v.in[3];
    bus_respcyc = v.in[2];
    ic_respack  = v.in[1];
    dc_respack  = v.in[0];
    ic_req      = BDW'(v.ic_d);
    dc_req      = BDW'(v.dc_d);
  endtask

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 0; ic_reqcyc = 0; dc_reqcyc = 0; bus_reqack = 0; bus_respcyc = 0;
    ic_respack = 0; dc_respack = 0; ic_req = '0; dc_req = '0;
  endtask

  initial begin
    // Reset, including a reset cycle with every input high.
    add("rst",     mkin(1, 0, 0, 0, 0, 0, 0, 0, 0), IC_A, DC_A, 7'd0, 16'h0);
    add("rst_all", mkin(1, 1, 1, 1, 1, 1, 1, 1, 1), IC_A, DC_A, 7'd0, 16'h0);
    // I-cache read alone, then a stray response beat in IDLE.
    read_txn("ic_rd", 0, 0);
    add("stray_idle", mkin(0, 0, 0, 0, 0, 0, 1, 1, 1), IC_A, DC_A, 7'd0, 16'h0);
    // Contention after reset: DC, IC, DC, IC.
    add("rst2", mkin(1, 0, 0, 0, 0, 0, 0, 0, 0), IC_A, DC_A, 7'd0, 16'h0);
    read_txn("rr1_dc", 1, 1);
    read_txn("rr2_ic", 0, 1);
    read_txn("rr3_dc", 1, 1);
    read_txn("rr4_ic", 0, 1);
    // D-cache write: address then 8 data beats, with a stall and a dropped reqcyc.
    add("wr_idle", mkin(0, 0, 0, 1, 0, 0, 0, 0, 0), IC_A, DC_A, 7'd0, 16'h0);
    add("wr_addr", mkin(0, 0, 0, 1, 0, 1, 0, 0, 0), IC_A, DC_A, mkex(1, 0, 1, 0, 0, 0, 1), DC_A);
    add("wr_stall", mkin(0, 0, 0, 1, 0, 0, 0, 0, 0), IC_A, 16'h0, mkex(1, 0, 0, 0, 0, 0, 1), 16'h0);
    for (int k = 0; k < 8; k++) begin
      if (k == 3)
        add("wr_drop", mkin(0, 0, 0, 0, 0, 0, 1, 0, 1), IC_A, 16'(k),
            mkex(0, 0, 0, 0, 0, 0, 1), 16'(k));
      add("wr_data", mkin(0, k == 7, 1, 1, 0, 1, 0, 0, 0), IC_A, 16'(k),
          mkex(1, 0, 1, 0, 0, 0, 1), 16'(k));
    end
    // New IC request seen on the last write beat is granted only after IDLE.
    add("post_wr_idle", mkin(0, 1, 1, 0, 0, 0, 1, 1, 0), IC_A, DC_A, 7'd0, 16'h0);
    add("ic_addr_wait", mkin(0, 1, 1, 0, 0, 0, 0, 0, 0), IC_A, DC_A, mkex(1, 0, 0, 0, 0, 0, 0), IC_A);
    add("ic_addr_ack",  mkin(0, 1, 1, 0, 0, 1, 0, 0, 0), IC_A, DC_A, mkex(1, 1, 0, 0, 0, 0, 0), IC_A);
    for (int k = 0; k < 4; k++)
      add("ic_beat_pre", mkin(0, 0, 0, 0, 0, 0, 1, 1, 0), IC_A, DC_A, mkex(0, 0, 0, 1, 0, 1, 0), 16'h0);
    // Reset at response beat 4, then a clean transaction from counter 0.
    add("rst_mid", mkin(1, 0, 0, 0, 0, 0, 1, 1, 0), IC_A, DC_A, 7'd0, 16'h0);
    read_txn("post_rst", 0, 0);
    add("post_rst_idle", mkin(0, 0, 0, 0, 0, 0, 1, 1, 1), IC_A, DC_A, 7'd0, 16'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check($sformatf("%s[%0d].outs", vecs[i].name, i),
            64'({bus_reqcyc, ic_reqack, dc_reqack, ic_respcyc, dc_respcyc, bus_respack, grant_dc}),
            64'(vecs[i].exp));
      check($sformatf("%s[%0d].bus_req", vecs[i].name, i), bus_req, 64'(vecs[i].exp_req));
    end

    // D-cache read with respack withheld for 3 beats.
    @(negedge clk);
    idle_inputs();
    dc_reqcyc = 1; dc_reqtag = {1'b1, 12'h0AB}; dc_req = 64'hBEEF;
    #1;
    check("hold_idle_grant", 64'(grant_dc), 64'd0);
    @(negedge clk);
    bus_reqack = 1;
    #1;
    check("hold_addr_tag", 64'(bus_reqtag), 64'h10AB);
    check("hold_addr_req", bus_req, 64'hBEEF);
    check("hold_addr_ack", 64'({dc_reqack, ic_reqack, grant_dc}), 64'b101);
    @(negedge clk);
    dc_reqcyc = 0; bus_reqack = 0; bus_respcyc = 1; ic_respack = 1; dc_respack = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_wait", 64'({dc_respcyc, ic_respcyc, bus_respack, grant_dc}), 64'b1001);
      @(negedge clk);
    end
    ic_respack = 0; dc_respack = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("hold_beat", 64'({dc_respcyc, bus_respack, grant_dc}), 64'b111);
      @(negedge clk);
    end
    #1;
    check("hold_done", 64'({dc_respcyc, bus_respack, grant_dc}), 64'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
